// File: rtl/pipe_arith_pkg.sv
// Shared constants and elaboration helpers for the pipelined adder/subtractor.
package pipe_arith_pkg;

  localparam int WIDTH_DEF  = 16;
  localparam int STAGES_DEF = 4;
  localparam int CHUNK      = WIDTH_DEF / STAGES_DEF;

  function automatic int chunk_width(input int width, input int stages);
    return (stages > 0) ? width / stages : width;
  endfunction

  // Legal only when the operand splits into STAGES equal, non-empty chunks.
  function automatic bit params_ok(input int width, input int stages);
    return (stages >= 1) && (width >= stages) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/add_chunk.sv
// W-bit ripple adder built from fulladd cells; also exposes the carry into its MSB.
module add_chunk #(
  parameter int W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         c_i,
  output logic [W-1:0] s_o,
  output logic         c_o,
  output logic         c_msb_o
);

  logic [W:0] carry;

  assign carry[0] = c_i;

  for (genvar i = 0; i < W; i++) begin : g_bit
    fulladd u_fa (
      .a_i (a_i[i]),
      .b_i (b_i[i]),
      .c_i (carry[i]),
      .s_o (s_o[i]),
      .c_o (carry[i+1])
    );
  end

  assign c_o     = carry[W];
  assign c_msb_o = carry[W-1];

endmodule

// File: rtl/fulladd.sv
// Single-bit full adder cell.
module fulladd (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/pipe_add_sub.sv
// Pipelined two's-complement adder/subtractor: one CHUNK per register stage,
// carry rippling between stages, global-stall valid/ready flow control.
module pipe_add_sub
  import pipe_arith_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int STAGES = STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int CW = chunk_width(WIDTH, STAGES);

  if (!params_ok(WIDTH, STAGES)) begin : g_bad_params
    $error("pipe_add_sub: WIDTH must be a positive multiple of STAGES");
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  logic             v_q   [STAGES];
  logic             v_d   [STAGES];
  logic             c_q   [STAGES];
  logic             c_d   [STAGES];
  logic [WIDTH-1:0] ska_q [STAGES];
  logic [WIDTH-1:0] ska_d [STAGES];
  logic [WIDTH-1:0] skb_q [STAGES];
  logic [WIDTH-1:0] skb_d [STAGES];
  logic [WIDTH-1:0] res_q [STAGES];
  logic [WIDTH-1:0] res_d [STAGES];
  logic             c_msb_q;
  logic             c_msb_d;

  logic [WIDTH-1:0] src_a   [STAGES];
  logic [WIDTH-1:0] src_b   [STAGES];
  logic [WIDTH-1:0] src_res [STAGES];
  logic             src_c   [STAGES];
  logic             src_v   [STAGES];

  logic [STAGES-1:0][CW-1:0] ch_sum;
  logic [STAGES-1:0]         ch_cout;
  logic [STAGES-1:0]         ch_cmsb;
  logic                      unused_tail;

  // Handshake: a beat moves on an edge where valid && ready. The whole pipe
  // advances when the output slot is empty or being drained, else it freezes.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv && !rst;

  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub ? ~c_in : c_in;

  // Skew registers shift consumed chunks out, so chunk k is always at the bottom.
  always_comb begin
    src_a[0]   = a;
    src_b[0]   = b_eff;
    src_c[0]   = cin_eff;
    src_v[0]   = in_valid;
    src_res[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      src_a[k]   = ska_q[k-1];
      src_b[k]   = skb_q[k-1];
      src_c[k]   = c_q[k-1];
      src_v[k]   = v_q[k-1];
      src_res[k] = res_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    add_chunk #(.W(CW)) u_add (
      .a_i     (src_a[k][CW-1:0]),
      .b_i     (src_b[k][CW-1:0]),
      .c_i     (src_c[k]),
      .s_o     (ch_sum[k]),
      .c_o     (ch_cout[k]),
      .c_msb_o (ch_cmsb[k])
    );
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      v_d[k]   = src_v[k];
      c_d[k]   = ch_cout[k];
      ska_d[k] = src_a[k] >> CW;
      skb_d[k] = src_b[k] >> CW;
      res_d[k] = src_res[k] | (WIDTH'(ch_sum[k]) << (k * CW));
    end
    c_msb_d = ch_cmsb[STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k]   <= 1'b0;
        c_q[k]   <= 1'b0;
        ska_q[k] <= '0;
        skb_q[k] <= '0;
        res_q[k] <= '0;
      end
      c_msb_q <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k]   <= v_d[k];
        c_q[k]   <= c_d[k];
        ska_q[k] <= ska_d[k];
        skb_q[k] <= skb_d[k];
        res_q[k] <= res_d[k];
      end
      c_msb_q <= c_msb_d;
    end
  end

  // Last-stage skew bits and inner-stage MSB carries have no consumer.
  assign unused_tail = ^{ska_q[STAGES-1], skb_q[STAGES-1], ch_cmsb};

  assign out_valid = v_q[STAGES-1];
  assign sum       = res_q[STAGES-1];
  assign c_out     = c_q[STAGES-1];
  assign ovf       = c_q[STAGES-1] ^ c_msb_q;

endmodule

// File: tb/tb_pipe_add_sub.sv
// Directed and randomised checks of pipe_add_sub (WIDTH=16, STAGES=4).
module tb_pipe_add_sub;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        c_in;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        c_out;
  logic        ovf;

  logic [17:0] exp_q[$];
  logic [17:0] cur_exp;
  logic [17:0] held;
  logic        held_v;
  logic [17:0] out_w;
  logic        rand_on;
  int          err_cnt;
  int          chk_cnt;
  int          out_cnt;

  pipe_add_sub #(.WIDTH(16), .STAGES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf)
  );

  assign out_w = {ovf, c_out, sum};

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", chk_cnt);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: {ovf, c_out, sum} for a + b + c_in or a - b - c_in.
  function automatic logic [17:0] model(input logic [15:0] av, input logic [15:0] bv,
                                        input logic cv, input logic sv);
    int ua, ub, sa, sb, ci, r, ur;
    logic co, ov;
    logic [31:0] u32;
    ua = int'(av);
    ub = int'(bv);
    sa = int'($signed(av));
    sb = int'($signed(bv));
    ci = cv ? 1 : 0;
    if (sv) begin
      ur = ua - ub - ci;
      r  = sa - sb - ci;
      co = (ua >= ub + ci);
    end else begin
      ur = ua + ub + ci;
      r  = sa + sb + ci;
      co = (ur > 65535);
    end
    ov  = (r > 32767) || (r < -32768);
    u32 = ur;
    return {ov, co, u32[15:0]};
  endfunction

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      default: return 16'($urandom_range(0, 65535));
    endcase
  endfunction

  // scoreboard: transfers are decided by values visible at the falling edge
  always @(negedge clk) begin
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_out", 32'(out_valid), 32'd0);
        else check("result", 32'(out_w), 32'(exp_q.pop_front()));
        out_cnt++;
        held_v = 1'b0;
      end else if (out_valid) begin
        if (held_v) check("hold", 32'(out_w), 32'(held));
        held   = out_w;
        held_v = 1'b1;
      end else begin
        held_v = 1'b0;
      end
      if (in_valid && in_ready) exp_q.push_back(cur_exp);
    end
  end

  // driver tasks: entered and left just after a rising edge
  task automatic send(input logic [15:0] av, input logic [15:0] bv,
                      input logic cv, input logic sv, input logic [17:0] ev);
    int n;
    n        = 0;
    a        = av;
    b        = bv;
    c_in     = cv;
    sub      = sv;
    cur_exp  = ev;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 1000) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic lat_beat(input logic [15:0] av, input logic [15:0] bv,
                          input logic cv, input logic sv, input logic [17:0] ev,
                          input logic rdy);
    out_ready = rdy;
    send(av, bv, cv, sv, ev);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("lat_early", 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    check("lat_due", 32'(out_valid), 32'd1);
    if (!rdy) begin
      check("stall_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    err_cnt   = 0;
    chk_cnt   = 0;
    out_cnt   = 0;
    held_v    = 1'b0;
    held      = '0;
    rand_on   = 1'b0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    c_in      = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b0;
    cur_exp   = '0;

    // reset state
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_c_out", 32'(c_out), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // latency and the three headline cases
    lat_beat(16'hFFFF, 16'h0001, 1'b0, 1'b0, 18'h10000, 1'b1);
    lat_beat(16'h7FFF, 16'h0001, 1'b0, 1'b0, 18'h28000, 1'b0);
    lat_beat(16'h0005, 16'h0007, 1'b1, 1'b1, 18'h0FFFD, 1'b1);

    // back-to-back directed vectors
    send(16'h0007, 16'h0005, 1'b0, 1'b1, 18'h10002);
    send(16'h8000, 16'h0001, 1'b0, 1'b1, 18'h37FFF);
    send(16'h0FFF, 16'h0001, 1'b1, 1'b0, 18'h01001);
    send(16'hFFFF, 16'h0000, 1'b1, 1'b0, 18'h10000);
    send(16'h8000, 16'h8000, 1'b0, 1'b0, 18'h30000);
    send(16'h0000, 16'h0000, 1'b1, 1'b1, 18'h0FFFF);
    send(16'h1234, 16'h1234, 1'b0, 1'b1, 18'h10000);
    drain("drain_directed");

    // streaming with a 4-cycle output stall
    out_cnt = 0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(16'(i), 16'(i * 'h1000), 1'b0, 1'b0, 18'(i * 'h1001));
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("stream_stall_in_ready", 32'(in_ready), 32'd0);
        check("stream_stall_valid", 32'(out_valid), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain("drain_stream");
    check("stream_count", 32'(out_cnt), 32'd8);

    // reset with three beats in flight
    send(16'h0101, 16'h0202, 1'b0, 1'b0, 18'h00303);
    send(16'h0404, 16'h0101, 1'b0, 1'b0, 18'h00505);
    send(16'h0303, 16'h0404, 1'b0, 1'b0, 18'h00707);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midrst_sum", 32'(sum), 32'd0);
    check("midrst_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("midrst_quiet", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    lat_beat(16'h1234, 16'h1111, 1'b0, 1'b0, 18'h02345, 1'b1);

    // random cross-check with random gaps and backpressure
    rand_on = 1'b1;
    fork
      begin
        logic [15:0] av;
        logic [15:0] bv;
        logic        cv;
        logic        sv;
        for (int n = 0; n < 10000; n++) begin
          repeat ($urandom_range(0, 1)) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
          end
          av = pick();
          bv = pick();
          cv = 1'($urandom_range(0, 1));
          sv = 1'($urandom_range(0, 1));
          send(av, bv, cv, sv, model(av, bv, cv, sv));
        end
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          @(posedge clk);
          #1;
          if (rand_on) out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain("drain_random");

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
